// File: rtl/arb_pkg.sv
// ============================================================================
// Module : arb_pkg
// Brief  : Shared state encodings and defaults for the arbiter/requester pair.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package arb_pkg;

  localparam int c_TIMEOUT_CYC_DEFAULT = 8;

  typedef logic [3:0] arb_state_t;

  localparam arb_state_t c_ST_IDLE = 4'b0001;
  localparam arb_state_t c_ST_WAIT = 4'b0010;
  localparam arb_state_t c_ST_XFER = 4'b0100;
  localparam arb_state_t c_ST_FIN  = 4'b1000;

endpackage

`default_nettype wire

// File: rtl/arb_requester_if.sv
// ============================================================================
// Module : arb_requester_if
// Brief  : Job-start and arbiter handshake bundle for arb_requester.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface arb_requester_if;

  logic       start;
  logic [3:0] len;
  logic       gen;
  logic       req;
  logic       beat;
  logic       busy;
  logic       done;
  logic       timeout;

  // master is the requester itself; slave is the job source plus arbiter side
  modport master (
    input  start, len, gen,
    output req, beat, busy, done, timeout
  );

  modport slave (
    output start, len, gen,
    input  req, beat, busy, done, timeout
  );

endinterface

`default_nettype wire

// File: rtl/wait_timer.sv
// ============================================================================
// Module : wait_timer
// Brief  : 8-bit ungranted-cycle counter; expired flags the last allowed cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wait_timer
  import arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = c_TIMEOUT_CYC_DEFAULT
) (
  input  wire logic clk,
  input  wire logic reset_n,
  input  wire logic clear_i,
  input  wire logic enable_i,
  output logic      expired_o
);

  localparam logic [7:0] c_LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = 8'd0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == c_LAST);

endmodule

`default_nettype wire

// File: rtl/arb_requester.sv
// ============================================================================
// Module : arb_requester
// Brief  : Issues a len-beat burst to an arbiter, re-arbitrating on grant loss
//          and abandoning after TIMEOUT_CYC ungranted cycles.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module arb_requester
  import arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = c_TIMEOUT_CYC_DEFAULT
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  arb_requester_if.master   bus
);

  arb_state_t state_q;
  arb_state_t state_d;
  logic [3:0] rem_q;
  logic [3:0] rem_d;
  logic       timeout_q;
  logic       timeout_d;

  logic       tmr_clear;
  logic       tmr_enable;
  logic       tmr_expired;
  logic       req_w;

  // Counter restarts on every entry into WAIT, so it is held clear elsewhere
  assign tmr_clear  = (state_q != c_ST_WAIT);
  assign tmr_enable = (state_q == c_ST_WAIT) && !bus.gen;

  wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wait_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_i   (tmr_clear),
    .enable_i  (tmr_enable),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= c_ST_IDLE;
      rem_q     <= 4'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    timeout_d = 1'b0;
    case (state_q)
      c_ST_IDLE: begin
        if (bus.start) begin
          if (bus.len != 4'd0) begin
            state_d = c_ST_WAIT;
            rem_d   = bus.len;
          end else begin
            state_d = c_ST_FIN;
          end
        end
      end
      c_ST_WAIT: begin
        if (bus.gen) begin
          rem_d   = rem_q - 4'd1;
          state_d = (rem_q == 4'd1) ? c_ST_FIN : c_ST_XFER;
        end else if (tmr_expired) begin
          state_d   = c_ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      c_ST_XFER: begin
        if (bus.gen) begin
          rem_d = rem_q - 4'd1;
          if (rem_q == 4'd1) begin
            state_d = c_ST_FIN;
          end
        end else begin
          state_d = c_ST_WAIT;
        end
      end
      c_ST_FIN: begin
        state_d = c_ST_IDLE;
      end
      default: begin
        state_d = c_ST_IDLE;
      end
    endcase
  end

  // req comes from the state register only, so gen can never loop back into it
  always_comb begin
    req_w       = (state_q == c_ST_WAIT) || (state_q == c_ST_XFER);
    bus.req     = req_w;
    bus.beat    = req_w && bus.gen;
    bus.busy    = (state_q != c_ST_IDLE);
    bus.done    = (state_q == c_ST_FIN);
    bus.timeout = timeout_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_arb_requester.sv
// ============================================================================
// Module : tb_arb_requester
// Brief  : Directed-vector bench for arb_requester (TIMEOUT_CYC = 8).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_arb_requester;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  arb_requester_if bus ();

  arb_requester #(
    .TIMEOUT_CYC (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector order: {req, beat, busy, done, timeout}
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    @(negedge clk);
    obs = {bus.req, bus.beat, bus.busy, bus.done, bus.timeout};
    n_tests++;
    if (obs !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_held: got %05b want 00000", obs);
    end
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    obs = {bus.req, bus.beat, bus.busy, bus.done, bus.timeout};
    n_tests++;
    if (obs !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_released_idle: got %05b want 00000", obs);
    end
    tick();
  endtask

  task automatic test_len3_gen_high();
    logic [4:0] exp [6] = '{5'b00000, 5'b11100, 5'b11100, 5'b11100, 5'b00110, 5'b00000};
    logic [4:0] obs;
    for (int i = 0; i < 6; i++) begin
      bus.start = (i == 0);
      bus.len   = 4'd3;
      bus.gen   = 1'b1;
      @(negedge clk);
      obs = {bus.req, bus.beat, bus.busy, bus.done, bus.timeout};
      n_tests++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL len3 cycle %0d: got %05b want %05b", i, obs, exp[i]);
      end
      tick();
    end
    bus.gen = 1'b0;
  endtask

  task automatic test_wait_then_grant();
    logic [4:0] exp [10] = '{5'b00000, 5'b10100, 5'b10100, 5'b10100, 5'b10100,
                            5'b10100, 5'b11100, 5'b11100, 5'b00110, 5'b00000};
    logic [4:0] obs;
    for (int i = 0; i < 10; i++) begin
      bus.start = (i == 0);
      bus.len   = 4'd2;
      bus.gen   = (i >= 6);
      @(negedge clk);
      obs = {bus.req, bus.beat, bus.busy, bus.done, bus.timeout};
      n_tests++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL wait_grant cycle %0d: got %05b want %05b", i, obs, exp[i]);
      end
      tick();
    end
    bus.gen = 1'b0;
  endtask

  task automatic test_timeout();
    logic [4:0] exp [11] = '{5'b00000, 5'b10100, 5'b10100, 5'b10100, 5'b10100, 5'b10100,
                            5'b10100, 5'b10100, 5'b10100, 5'b00001, 5'b00000};
    logic [4:0] obs;
    for (int i = 0; i < 11; i++) begin
      bus.start = (i == 0);
      bus.len   = 4'd4;
      bus.gen   = 1'b0;
      @(negedge clk);
      obs = {bus.req, bus.beat, bus.busy, bus.done, bus.timeout};
      n_tests++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL timeout cycle %0d: got %05b want %05b", i, obs, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_grant_loss();
    logic [4:0] exp [10] = '{5'b00000, 5'b11100, 5'b11100, 5'b10100, 5'b10100,
                            5'b10100, 5'b11100, 5'b11100, 5'b00110, 5'b00000};
    logic [4:0] obs;
    for (int i = 0; i < 10; i++) begin
      bus.start = (i == 0);
      bus.len   = 4'd4;
      bus.gen   = (i == 1) || (i == 2) || (i == 6) || (i == 7);
      @(negedge clk);
      obs = {bus.req, bus.beat, bus.busy, bus.done, bus.timeout};
      n_tests++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL grant_loss cycle %0d: got %05b want %05b", i, obs, exp[i]);
      end
      tick();
    end
    bus.gen = 1'b0;
  endtask

  task automatic test_len0();
    logic [4:0] exp [3] = '{5'b00000, 5'b00110, 5'b00000};
    logic [4:0] obs;
    for (int i = 0; i < 3; i++) begin
      bus.start = (i == 0);
      bus.len   = 4'd0;
      bus.gen   = 1'b1;
      @(negedge clk);
      obs = {bus.req, bus.beat, bus.busy, bus.done, bus.timeout};
      n_tests++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL len0 cycle %0d: got %05b want %05b", i, obs, exp[i]);
      end
      tick();
    end
    bus.gen = 1'b0;
  endtask

  task automatic test_start_ignored();
    logic [4:0] exp [6] = '{5'b00000, 5'b10100, 5'b11100, 5'b00110, 5'b00000, 5'b00000};
    logic [4:0] obs;
    for (int i = 0; i < 6; i++) begin
      bus.start = (i <= 3);
      bus.len   = (i == 0) ? 4'd1 : 4'd5;
      bus.gen   = (i >= 2);
      @(negedge clk);
      obs = {bus.req, bus.beat, bus.busy, bus.done, bus.timeout};
      n_tests++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL start_ignored cycle %0d: got %05b want %05b", i, obs, exp[i]);
      end
      tick();
    end
    bus.start = 1'b0;
    bus.gen   = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [4:0] exp_a [4] = '{5'b00000, 5'b11100, 5'b11100, 5'b11100};
    logic [4:0] exp_b [4] = '{5'b00000, 5'b11100, 5'b00110, 5'b00000};
    logic [4:0] obs;
    for (int i = 0; i < 4; i++) begin
      bus.start = (i == 0);
      bus.len   = 4'd5;
      bus.gen   = 1'b1;
      @(negedge clk);
      obs = {bus.req, bus.beat, bus.busy, bus.done, bus.timeout};
      n_tests++;
      if (obs !== exp_a[i]) begin
        n_fail++;
        $display("FAIL async_pre cycle %0d: got %05b want %05b", i, obs, exp_a[i]);
      end
      if (i < 3) tick();
    end
    // Mid-cycle, away from any clock edge
    #2;
    reset_n = 1'b0;
    #1;
    obs = {bus.req, bus.beat, bus.busy, bus.done, bus.timeout};
    n_tests++;
    if (obs !== 5'b00000) begin
      n_fail++;
      $display("FAIL async_drop: got %05b want 00000", obs);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      obs = {bus.req, bus.beat, bus.busy, bus.done, bus.timeout};
      n_tests++;
      if (obs !== 5'b00000) begin
        n_fail++;
        $display("FAIL async_held cycle %0d: got %05b want 00000", i, obs);
      end
    end
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.start = (i == 0);
      bus.len   = 4'd1;
      bus.gen   = 1'b1;
      @(negedge clk);
      obs = {bus.req, bus.beat, bus.busy, bus.done, bus.timeout};
      n_tests++;
      if (obs !== exp_b[i]) begin
        n_fail++;
        $display("FAIL async_restart cycle %0d: got %05b want %05b", i, obs, exp_b[i]);
      end
      tick();
    end
    bus.gen = 1'b0;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.len   = 4'd0;
    bus.gen   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_len3_gen_high();
    test_wait_then_grant();
    test_timeout();
    test_grant_loss();
    test_len0();
    test_start_ignored();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
